// File: rtl/des_blk_requester.sv
// Single-outstanding requester in front of the DES core: takes a block plus its
// key settings from upstream, issues it to the core, and returns the result or an error.
module des_blk_requester #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [63:0]      blk_in,
  input  logic             blk_in_valid,
  output logic             blk_in_ready,
  input  logic [63:0]      key_in,
  input  logic             mode_in,
  input  logic             verify_in,
  output logic [63:0]      core_data_out,
  output logic [63:0]      core_key_out,
  output logic             core_mode_out,
  output logic             core_verify_out,
  output logic             core_in_valid,
  input  logic             core_ready_in,
  input  logic [63:0]      core_result_in,
  input  logic             core_result_valid_in,
  input  logic             core_err_in,
  output logic [63:0]      blk_out,
  output logic             blk_out_err,
  output logic             blk_out_valid,
  input  logic             blk_out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] blk_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  typedef struct packed {
    logic [63:0] data;
    logic [63:0] key;
    logic        mode;
    logic        verify;
  } req_t;

  state_t        state, state_nxt;
  req_t          req_q;
  logic [TW-1:0] tcnt;
  logic          timeout;

  assign timeout = (tcnt == T_LAST);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (blk_in_valid && blk_in_ready) state_nxt = ISSUE;
      ISSUE: if (core_ready_in) state_nxt = WAIT;
      WAIT:  if (core_err_in || core_result_valid_in || timeout) state_nxt = HOLD;
      HOLD:  if (blk_out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is gated by reset so upstream never sees a handshake while held in reset.
  always_comb begin
    blk_in_ready  = (state == IDLE) && rst_n_in;
    busy          = (state != IDLE);
    core_in_valid = (state == ISSUE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      req_q         <= '0;
      tcnt          <= '0;
      blk_out       <= '0;
      blk_out_err   <= 1'b0;
      blk_out_valid <= 1'b0;
      blk_count     <= '0;
      err_count     <= '0;
    end else begin
      if (state == IDLE && blk_in_valid)
        req_q <= '{data: blk_in, key: key_in, mode: mode_in, verify: verify_in};

      if (state == ISSUE && core_ready_in) tcnt <= '0;
      else if (state == WAIT)              tcnt <= tcnt + TW'(1);

      // Core error outranks a simultaneous result; timeout only if neither arrived.
      if (state == WAIT) begin
        if (core_err_in) begin
          blk_out       <= '0;
          blk_out_err   <= 1'b1;
          blk_out_valid <= 1'b1;
        end else if (core_result_valid_in) begin
          blk_out       <= core_result_in;
          blk_out_err   <= 1'b0;
          blk_out_valid <= 1'b1;
        end else if (timeout) begin
          blk_out       <= '0;
          blk_out_err   <= 1'b1;
          blk_out_valid <= 1'b1;
        end
      end

      if (state == HOLD && blk_out_ready) begin
        blk_out_valid <= 1'b0;
        blk_count     <= blk_count + CNT_W'(1);
        if (blk_out_err && err_count != '1) err_count <= err_count + CNT_W'(1);
      end
    end
  end

  assign core_data_out   = req_q.data;
  assign core_key_out    = req_q.key;
  assign core_mode_out   = req_q.mode;
  assign core_verify_out = req_q.verify;

endmodule
